spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 23 ++
 rtl/spi_arbiter_rr.sv | 30 +++
 rtl/spi_arbiter.sv | 154 +++++++++++++++
 tb/tb_spi_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and default timing for the SPI bus arbiter.
// Imported by the arbiter top level and its round-robin selector.
package spi_arb_pkg;

    localparam int CS_SETUP_DEF     = 4;
    localparam int CS_HOLD_DEF      = 4;
    localparam int IDLE_TIMEOUT_DEF = 1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_NEXT,
        S_WAIT,
        S_HOLD
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin selector: search starts one past last_grant.
// Produces a one-hot grant, or all zeros when nobody requests.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt
);

    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sel = IW'((int'(last_grant) + i) % NREQ);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NREQ requesters with chip-select framing,
// per-byte handshakes and an inter-byte stall timeout.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NREQ         = 3,
    parameter  int CS_SETUP     = CS_SETUP_DEF,
    parameter  int CS_HOLD      = CS_HOLD_DEF,
    parameter  int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    localparam int IW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              m_start,
    output logic [7:0]        m_txdata,
    input  logic              m_done,
    input  logic [7:0]        m_rxdata,
    output logic [NREQ-1:0]   ss_n,
    output logic [NREQ-1:0]   grant,
    output logic              timeout_err
);

    localparam int CW = $clog2(max3(CS_SETUP, CS_HOLD, IDLE_TIMEOUT)) + 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   lgnt_q, lgnt_d;
    logic            lastb_q, lastb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            tmo_q, tmo_d;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_valid),
        .last_grant (lgnt_q),
        .gnt        (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = IW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        lgnt_d      = lgnt_q;
        lastb_d     = lastb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        tmo_d       = 1'b0;
        req_ready   = '0;
        m_start     = 1'b0;
        m_txdata    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                req_ready = grant_q;
                if (req_valid[gidx_q]) begin
                    m_start  = 1'b1;
                    m_txdata = req_data[8*gidx_q +: 8];
                    lastb_d  = req_last[gidx_q];
                    state_d  = S_WAIT;
                end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                // Counter is re-armed here so the stall window starts fresh.
                if (m_done) begin
                    rsp_data_d  = m_rxdata;
                    rsp_valid_d = grant_q;
                    cnt_d       = '0;
                    state_d     = lastb_q ? S_HOLD : S_NEXT;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    grant_d = '0;
                    lgnt_d  = gidx_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            lgnt_q      <= IW'(NREQ - 1);
            lastb_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            lgnt_q      <= lgnt_d;
            lastb_q     <= lastb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tmo_q       <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign ss_n        = ~grant_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: framing, round-robin order, timeout,
// spurious m_done and mid-transaction reset.
module tb_spi_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              m_start;
    logic [7:0]        m_txdata;
    logic              m_done;
    logic [7:0]        m_rxdata;
    logic [NREQ-1:0]   ss_n;
    logic [NREQ-1:0]   grant;
    logic              timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    spi_arbiter #(.NREQ(NREQ)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .m_start       (m_start),
        .m_txdata      (m_txdata),
        .m_done        (m_done),
        .m_rxdata      (m_rxdata),
        .ss_n          (ss_n),
        .grant         (grant),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic echo(input logic [7:0] d);
        tick();
        tick();
        m_done   = 1'b1;
        m_rxdata = ~d;
        tick();
        m_done   = 1'b0;
    endtask

    // Single-byte transaction for requester g; caller has raised valid/data/last.
    task automatic run_txn(input int g, input logic [7:0] d);
        int              n;
        logic            ok;
        logic [NREQ-1:0] gm;
        logic [7:0]      nd;
        gm = NREQ'(1) << g;
        nd = ~d;
        n = 0;
        while (grant == '0 && n < 20) begin tick(); n++; end
        chk($sformatf("grant_req%0d", g), 32'(grant), 32'(gm));
        n = 0;
        while (req_ready[g] !== 1'b1 && n < 20) begin tick(); n++; end
        chk($sformatf("ready_req%0d", g), 32'(req_ready), 32'(gm));
        chk($sformatf("m_start_req%0d", g), 32'(m_start), 32'd1);
        chk($sformatf("txdata_req%0d", g), 32'(m_txdata), 32'(d));
        tick();
        req_valid[g] = 1'b0;
        echo(d);
        chk($sformatf("rsp_valid_req%0d", g), 32'(rsp_valid), 32'(gm));
        chk($sformatf("rsp_data_req%0d", g), 32'(rsp_data), 32'(nd));
        ok = 1'b1;
        n = 0;
        while (ss_n !== '1 && n < 20) begin
            if ($countones(~ss_n) > 1 || (req_ready & ~gm) != '0 || grant != gm)
                ok = 1'b0;
            tick();
            n++;
        end
        chk($sformatf("excl_req%0d", g), 32'(ok), 32'd1);
        chk($sformatf("release_req%0d", g), 32'(grant), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        m_done    = 1'b0;
        m_rxdata  = '0;
        tick();
        tick();
        chk("rst_ss_n", 32'(ss_n), 32'h7);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_m_start", 32'(m_start), 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_txdata", 32'(m_txdata), 32'h0);
        rst_n = 1'b1;
        tick();

        // req0: two bytes A5, 3C
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'hA5;
        req_last[0]   = 1'b0;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_ss_setup", 32'(ss_n), 32'h6);
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t1_setup_cycles", 32'(n), 32'd4);
        chk("t1_start0", 32'(m_start), 32'd1);
        chk("t1_tx0", 32'(m_txdata), 32'hA5);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("t1_start_wait", 32'(m_start), 32'd0);
        chk("t1_ss_wait", 32'(ss_n), 32'h6);
        echo(8'hA5);
        chk("t1_rsp_v0", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_d0", 32'(rsp_data), 32'h5A);
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h3C;
        req_last[0]   = 1'b1;
        #1;
        chk("t1_start1", 32'(m_start), 32'd1);
        chk("t1_tx1", 32'(m_txdata), 32'h3C);
        tick();
        req_valid[0] = 1'b0;
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
        echo(8'h3C);
        chk("t1_rsp_v1", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_d1", 32'(rsp_data), 32'hC3);
        n = 0;
        while (ss_n !== 3'b111 && n < 20) begin tick(); n++; end
        chk("t1_hold_cycles", 32'(n), 32'd4);
        chk("t1_grant_clr", 32'(grant), 32'h0);

        // spurious m_done while idle
        m_done   = 1'b1;
        m_rxdata = 8'hEE;
        tick();
        m_done = 1'b0;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t2_rsp_data", 32'(rsp_data), 32'hC3);
        chk("t2_grant", 32'(grant), 32'h0);
        chk("t2_m_start", 32'(m_start), 32'h0);

        // simultaneous requests right after reset: order 0,1,2
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req_data  = {8'h23, 8'h22, 8'h21};
        req_last  = 3'b111;
        req_valid = 3'b111;
        run_txn(0, 8'h21);
        run_txn(1, 8'h22);
        run_txn(2, 8'h23);

        // req2 must wait while req0 owns the bus; then lone re-grant of req2
        req_data[7:0] = 8'h11;
        req_valid[0]  = 1'b1;
        tick();
        chk("t4_grant0", 32'(grant), 32'h1);
        req_data[23:16] = 8'h22;
        req_valid[2]    = 1'b1;
        #1;
        chk("t4_ready2_blocked", 32'(req_ready[2]), 32'h0);
        run_txn(0, 8'h11);
        run_txn(2, 8'h22);
        req_data[23:16] = 8'h33;
        req_valid[2]    = 1'b1;
        run_txn(2, 8'h33);

        // req1 stalls after a non-last byte
        req_data[15:8] = 8'h44;
        req_last[1]    = 1'b0;
        req_valid[1]   = 1'b1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5_grant", 32'(grant), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        echo(8'h44);
        chk("t5_rsp_d", 32'(rsp_data), 32'hBB);
        n = 0;
        while (timeout_err !== 1'b1 && n < 1100) begin tick(); n++; end
        chk("t5_stall_cycles", 32'(n), 32'd1000);
        chk("t5_ss_hold", 32'(ss_n), 32'h5);
        tick();
        chk("t5_tmo_pulse", 32'(timeout_err), 32'h0);
        n = 0;
        while (ss_n !== 3'b111 && n < 20) begin tick(); n++; end
        chk("t5_hold_left", 32'(n), 32'd3);
        chk("t5_grant_clr", 32'(grant), 32'h0);

        // reset during WAIT
        req_data[7:0] = 8'h55;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t6_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        m_done   = 1'b1;
        m_rxdata = 8'h99;
        rst_n    = 1'b0;
        #1;
        chk("t6_ss_async", 32'(ss_n), 32'h7);
        chk("t6_grant_async", 32'(grant), 32'h0);
        tick();
        chk("t6_rsp_in_rst", 32'(rsp_valid), 32'h0);
        m_done = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk("t6_rsp_after", 32'(rsp_valid), 32'h0);
        chk("t6_rsp_data", 32'(rsp_data), 32'h0);
        req_data[7:0] = 8'h66;
        req_valid[0]  = 1'b1;
        run_txn(0, 8'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
